buffer_sched: RTL and testbench

BUFFER_SCHED -- requirements
Module: buffer_sched

---
 rtl/router_pkg.sv | 13 +
 rtl/buffer_sched_free_pick4.sv | 22 ++
 rtl/buffer_sched.sv | 101 ++++++++++
 tb/tb_buffer_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants for the buffer scheduler.
//   NUM_BUF   : number of router buffers (indices 1..NUM_BUF, 0 = none)
//   NUM_PORT  : number of requesting input ports
//   BUF_IDX_W : width of a buffer index
//   PRI_W     : width of a per-port / per-buffer priority (0 = invalid/empty)
//   NO_BUF    : the "no buffer" index
package router_pkg;
  localparam int NUM_BUF   = 7;
  localparam int NUM_PORT  = 4;
  localparam int BUF_IDX_W = 3;
  localparam int PRI_W     = 3;
  localparam logic [BUF_IDX_W-1:0] NO_BUF = 3'b000;
endpackage

// File: rtl/buffer_sched_free_pick4.sv
// free_pick4: combinational search for the four lowest empty buffers.
//   empty : bit b-1 set when buffer b is empty
//   pick  : pick[k] = index of the k-th lowest empty buffer, ascending;
//           slots beyond the number of empty buffers read NO_BUF
module free_pick4
  import router_pkg::*;
(
  input  logic [NUM_BUF-1:0]             empty,
  output logic [3:0][BUF_IDX_W-1:0]      pick
);
  always_comb begin
    logic [2:0] n;
    pick = '0;
    n    = '0;
    for (int b = 0; b < NUM_BUF; b++) begin
      if (empty[b] && !n[2]) begin
        pick[n[1:0]] = BUF_IDX_W'(b + 1);
        n = n + 3'd1;
      end
    end
  end
endmodule

// File: rtl/buffer_sched.sv
// buffer_sched: round-robin allocation of router buffers to input ports.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req/req_pri : per-port level request and 3-bit priority (0 = invalid)
//   rel_valid/rel_buf : one-cycle release of a buffer by index
//   gnt/gnt_buf : registered one-cycle grant pulse and granted buffer per port
//   buf_pri     : stored priority per buffer (0 = empty)
//   free_cnt/full : empty-buffer count and full flag
//   rel_err     : one-cycle pulse after an illegal release
module buffer_sched #(
  parameter int NUM_BUF  = router_pkg::NUM_BUF,
  parameter int NUM_PORT = router_pkg::NUM_PORT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [11:0]           req_pri,
  input  logic                  rel_valid,
  input  logic [2:0]            rel_buf,
  output logic [3:0]            gnt,
  output logic [11:0]           gnt_buf,
  output logic [20:0]           buf_pri,
  output logic [2:0]            free_cnt,
  output logic                  full,
  output logic                  rel_err
);
  localparam int IW = router_pkg::BUF_IDX_W;
  localparam int PW = router_pkg::PRI_W;

  logic [NUM_BUF-1:0][PW-1:0]   pri_q, pri_d;
  logic [NUM_PORT-1:0][PW-1:0]  pri_a;
  logic [NUM_PORT-1:0][IW-1:0]  gbuf_q, gbuf_d;
  logic [NUM_PORT-1:0]          gnt_d, elig;
  logic [NUM_BUF-1:0]           empty;
  logic [NUM_BUF:0]             occ8;
  logic [3:0][IW-1:0]           pick;
  logic [1:0]                   rr_ptr, rr_d;
  logic                         rel_ok, rel_err_d;

  assign pri_a = req_pri;

  always_comb begin
    for (int b = 0; b < NUM_BUF; b++) empty[b] = (pri_q[b] == '0);
  end

  // Bit 0 stands for "no buffer" and is never occupied, so rel_buf indexes directly.
  assign occ8   = {~empty, 1'b0};
  assign rel_ok = rel_valid && occ8[rel_buf];
  assign rel_err_d = rel_valid && !rel_ok;

  // A port whose grant pulse is currently high is not re-granted this edge.
  assign elig = req & ~gnt & {pri_a[3] != '0, pri_a[2] != '0, pri_a[1] != '0, pri_a[0] != '0};

  free_pick4 u_pick (.empty(empty), .pick(pick));

  // Allocation sees pre-release occupancy: a buffer being released is still
  // occupied, so it cannot also be picked on the same edge.
  always_comb begin
    logic [1:0] p;
    logic [1:0] slot;
    logic       more;
    gnt_d  = '0;
    gbuf_d = '0;
    pri_d  = pri_q;
    rr_d   = rr_ptr;
    slot   = '0;
    more   = 1'b1;
    for (int k = 0; k < NUM_PORT; k++) begin
      p = rr_ptr + 2'(k);
      if (elig[p] && more && pick[slot] != router_pkg::NO_BUF) begin
        gnt_d[p]  = 1'b1;
        gbuf_d[p] = pick[slot];
        pri_d[3'(pick[slot] - 3'd1)] = pri_a[p];
        rr_d  = p + 2'd1;
        more  = (slot != 2'd3);
        slot  = slot + 2'd1;
      end
    end
    if (rel_ok) pri_d[3'(rel_buf - 3'd1)] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q   <= '0;
      gnt     <= '0;
      gbuf_q  <= '0;
      rr_ptr  <= '0;
      rel_err <= 1'b0;
    end else begin
      pri_q   <= pri_d;
      gnt     <= gnt_d;
      gbuf_q  <= gbuf_d;
      rr_ptr  <= rr_d;
      rel_err <= rel_err_d;
    end
  end

  assign gnt_buf  = gbuf_q;
  assign buf_pri  = pri_q;
  assign free_cnt = 3'($countones(empty));
  assign full     = (free_cnt == 3'd0);
endmodule

// File: tb/tb_buffer_sched.sv
module tb_buffer_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_pri;
  logic        rel_valid;
  logic [2:0]  rel_buf;
  logic [3:0]  gnt;
  logic [11:0] gnt_buf;
  logic [20:0] buf_pri;
  logic [2:0]  free_cnt;
  logic        full;
  logic        rel_err;

  int nchk = 0;
  int nfail = 0;

  buffer_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_pri(req_pri),
    .rel_valid(rel_valid), .rel_buf(rel_buf), .gnt(gnt), .gnt_buf(gnt_buf),
    .buf_pri(buf_pri), .free_cnt(free_cnt), .full(full), .rel_err(rel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] pri;
    logic        rv;
    logic [2:0]  rb;
    logic [3:0]  gnt;
    logic [11:0] gb;
    logic [2:0]  fc;
    logic        full;
    logic        re;
    logic [20:0] bp;
    logic [1:0]  rr;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_pri = '0; rel_valid = 1'b0; rel_buf = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Main sequence: all pri 3 (12'h6DB); each row's outputs are after its edge.
    //          req   pri      rv rb  gnt   gb       fc full re bp          rr
    tv[0]  = '{4'hF, 12'h6DB, 0, 0, 4'hF, 12'h8D1, 3, 0, 0, 21'h0006DB, 0};
    tv[1]  = '{4'h0, 12'h6DB, 0, 0, 4'h0, 12'h000, 3, 0, 0, 21'h0006DB, 0};
    tv[2]  = '{4'hC, 12'h6DB, 0, 0, 4'hC, 12'hD40, 1, 0, 0, 21'h01B6DB, 0};
    tv[3]  = '{4'h0, 12'h6DB, 0, 0, 4'h0, 12'h000, 1, 0, 0, 21'h01B6DB, 0};
    tv[4]  = '{4'h6, 12'h6DB, 0, 0, 4'h2, 12'h038, 0, 1, 0, 21'h0DB6DB, 2};
    tv[5]  = '{4'h4, 12'h6DB, 1, 3, 4'h0, 12'h000, 1, 0, 0, 21'h0DB61B, 2};
    tv[6]  = '{4'h4, 12'h6DB, 0, 0, 4'h4, 12'h0C0, 0, 1, 0, 21'h0DB6DB, 3};
    tv[7]  = '{4'h0, 12'h6DB, 1, 0, 4'h0, 12'h000, 0, 1, 1, 21'h0DB6DB, 3};
    tv[8]  = '{4'h0, 12'h6DB, 1, 5, 4'h0, 12'h000, 1, 0, 0, 21'h0D86DB, 3};
    tv[9]  = '{4'h0, 12'h6DB, 1, 5, 4'h0, 12'h000, 1, 0, 1, 21'h0D86DB, 3};
    tv[10] = '{4'h0, 12'h6DB, 0, 0, 4'h0, 12'h000, 1, 0, 0, 21'h0D86DB, 3};

    do_reset();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_buf", 32'(gnt_buf), 32'h0);
    chk("rst_buf_pri", 32'(buf_pri), 32'h0);
    chk("rst_free_cnt", 32'(free_cnt), 32'd7);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_rel_err", 32'(rel_err), 32'h0);

    for (int i = 0; i < 11; i++) begin
      req = tv[i].req; req_pri = tv[i].pri; rel_valid = tv[i].rv; rel_buf = tv[i].rb;
      step();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("v%0d_gnt_buf", i), 32'(gnt_buf), 32'(tv[i].gb));
      chk($sformatf("v%0d_free_cnt", i), 32'(free_cnt), 32'(tv[i].fc));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].full));
      chk($sformatf("v%0d_rel_err", i), 32'(rel_err), 32'(tv[i].re));
      chk($sformatf("v%0d_buf_pri", i), 32'(buf_pri), 32'(tv[i].bp));
      chk($sformatf("v%0d_rr_ptr", i), 32'(dut.rr_ptr), 32'(tv[i].rr));
    end
    rel_valid = 1'b0; req = '0;

    // Asynchronous reset mid-operation with four buffers occupied and requests pending.
    do_reset();
    req = 4'hF; req_pri = 12'h6DB;
    step();
    chk("mr_pre_gnt", 32'(gnt), 32'hF);
    req = 4'h3;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_gnt_buf", 32'(gnt_buf), 32'h0);
    chk("mr_buf_pri", 32'(buf_pri), 32'h0);
    chk("mr_free_cnt", 32'(free_cnt), 32'd7);
    chk("mr_full", 32'(full), 32'h0);
    chk("mr_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    #1 rst_n = 1'b1;
    #1;
    chk("mr_rel_gnt", 32'(gnt), 32'h0);
    chk("mr_rel_free_cnt", 32'(free_cnt), 32'd7);
    step();
    chk("mr_after_gnt", 32'(gnt), 32'h3);
    chk("mr_after_gnt_buf", 32'(gnt_buf), 32'h011);
    chk("mr_after_free_cnt", 32'(free_cnt), 32'd5);
    req = '0;

    // Zero priority is never granted; port 1 with pri 5 takes buffer 1.
    do_reset();
    req = 4'h3; req_pri = 12'h028;
    step();
    chk("p0_gnt", 32'(gnt), 32'h2);
    chk("p0_gnt_buf", 32'(gnt_buf), 32'h008);
    chk("p0_buf_pri", 32'(buf_pri), 32'h5);
    req = 4'h1;
    step();
    chk("p0_gnt2", 32'(gnt), 32'h0);
    chk("p0_free_cnt", 32'(free_cnt), 32'd6);
    step();
    chk("p0_gnt3", 32'(gnt), 32'h0);
    chk("p0_buf_pri2", 32'(buf_pri), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
